// File: rtl/ysyx_22041071_dmem_responder.sv
// Data-memory responder for the MEM stage: valid/ready request and response channels,
// DEPTH x 64-bit array with LATENCY busy cycles per access. Optional macro: DMEM_RANGE_CHK_EN.
module ysyx_22041071_dmem_responder #(
    parameter int unsigned DEPTH     = 4096,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter int unsigned LATENCY   = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_wen_i,
    input  logic [63:0] req_addr_i,
    input  logic [63:0] req_wdata_i,
    input  logic [63:0] req_wmask_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [63:0] resp_rdata_o,
    output logic        resp_err_o
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [7:0]  CNT_INIT = 8'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic        wen_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [63:0] wmask_q;
    logic [63:0] rdata_q;
    logic        err_q;

    logic [63:0] mem [DEPTH];

    logic [63:0]   addrOff;
    logic [AW-1:0] wordIdx;
    logic          inRange;
    logic          access;
    logic [63:0]   oldWord;
    logic [63:0]   newWord;

    // Unsigned 64-bit offset: addresses below BASE_ADDR wrap to a huge index
    assign addrOff = addr_q - BASE_ADDR;
    assign wordIdx = addrOff[AW+2:3];

`ifdef DMEM_RANGE_CHK_EN
    logic [2:0] unusedOffBits;
    assign inRange       = (addrOff >> 3) < 64'(DEPTH);
    assign unusedOffBits = addrOff[2:0];
`else
    logic [63-AW:0] unusedOffBits;
    assign inRange       = 1'b1;
    assign unusedOffBits = {addrOff[63:AW+3], addrOff[2:0]};
`endif

    assign access  = (state_q == BUSY) && (cnt_q == 8'd0);
    assign oldWord = mem[wordIdx];
    assign newWord = (oldWord & ~wmask_q) | (wdata_q & wmask_q);

    always_ff @(posedge clk_i) begin
        if (rst_ni && access && wen_q && inRange) begin
            mem[wordIdx] <= newWord;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            wen_q   <= 1'b0;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
            wmask_q <= 64'd0;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        wen_q   <= req_wen_i;
                        addr_q  <= req_addr_i;
                        wdata_q <= req_wdata_i;
                        wmask_q <= req_wmask_i;
                        cnt_q   <= CNT_INIT;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q != 8'd0) begin
                        cnt_q <= cnt_q - 8'd1;
                    end else begin
                        rdata_q <= (!wen_q && inRange) ? oldWord : 64'd0;
                        err_q   <= !inRange;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready_i) begin
                        rdata_q <= 64'd0;
                        err_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Gated by reset so the requester never sees ready while reset is held
    assign req_ready_o  = rst_ni && (state_q == IDLE);
    assign resp_valid_o = (state_q == RESP);
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;

endmodule

// File: tb/tb_ysyx_22041071_dmem_responder.sv
// Self-checking bench for ysyx_22041071_dmem_responder against a word-addressed reference memory.
// Works with or without DMEM_RANGE_CHK_EN defined.
module tb_ysyx_22041071_dmem_responder;

    localparam int unsigned DEPTH = 4096;
    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int          LAT   = 3;

    logic        clk = 1'b0;
    logic        rstN;
    logic        reqValid;
    logic        reqReady;
    logic        reqWen;
    logic [63:0] reqAddr;
    logic [63:0] reqWdata;
    logic [63:0] reqWmask;
    logic        respValid;
    logic        respReady;
    logic [63:0] respRdata;
    logic        respErr;

    int vectors     = 0;
    int miscompares = 0;
    int cycle       = 0;

    logic [63:0] modelMem [longint unsigned];

    ysyx_22041071_dmem_responder #(
        .DEPTH(DEPTH),
        .BASE_ADDR(BASE),
        .LATENCY(LAT)
    ) dut (
        .clk_i(clk),
        .rst_ni(rstN),
        .req_valid_i(reqValid),
        .req_ready_o(reqReady),
        .req_wen_i(reqWen),
        .req_addr_i(reqAddr),
        .req_wdata_i(reqWdata),
        .req_wmask_i(reqWmask),
        .resp_valid_o(respValid),
        .resp_ready_i(respReady),
        .resp_rdata_o(respRdata),
        .resp_err_o(respErr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Reference model: byte address -> word number, range rule, wrap rule
    function automatic longint unsigned wordNum(input logic [63:0] a);
        logic [63:0] off;
        off = a - BASE;
        return longint'(off / 64'd8);
    endfunction

    function automatic bit modelInRange(input logic [63:0] a);
`ifdef DMEM_RANGE_CHK_EN
        return wordNum(a) < longint'(DEPTH);
`else
        return 1'b1;
`endif
    endfunction

    function automatic longint unsigned modelKey(input logic [63:0] a);
        return wordNum(a) % longint'(DEPTH);
    endfunction

    function automatic logic [63:0] mergeBytes(input logic [63:0] oldW, input logic [63:0] newW,
                                               input logic [63:0] mask);
        logic [63:0] r;
        r = oldW;
        for (int b = 0; b < 8; b++) begin
            if (mask[b*8 +: 8] == 8'hff) r[b*8 +: 8] = newW[b*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [63:0] randomMask();
        logic [63:0] m;
        m = 64'd0;
        for (int b = 0; b < 8; b++) begin
            if ($urandom_range(0, 1) == 1) m[b*8 +: 8] = 8'hff;
        end
        return m;
    endfunction

    // One full transaction with optional response backpressure, checked against the model
    task automatic applyStimulus(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                                 input logic [63:0] wmask, input int stall);
        logic [63:0]     expData;
        logic            expErr;
        logic [63:0]     heldData;
        bit              ok;
        longint unsigned key;
        int              accCycle;
        int              respCycle;
        int              guard;
        ok      = modelInRange(addr);
        key     = modelKey(addr);
        expErr  = !ok;
        expData = (!wen && ok) ? modelMem[key] : 64'd0;

        @(negedge clk);
        reqValid  = 1'b1;
        reqWen    = wen;
        reqAddr   = addr;
        reqWdata  = wdata;
        reqWmask  = wmask;
        respReady = 1'b0;
        guard = 0;
        while (reqReady !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("acceptTimeout", 64'(guard < 50), 64'd1);
        accCycle = cycle;

        @(negedge clk);
        reqValid = 1'b0;
        reqAddr  = {$urandom, $urandom};
        reqWdata = {$urandom, $urandom};
        guard = 0;
        while (respValid !== 1'b1 && guard < 600) begin
            @(negedge clk);
            guard++;
        end
        respCycle = cycle;
        checkOutput("latency", 64'(respCycle - accCycle), 64'(1 + LAT));
        checkOutput("rdata", respRdata, expData);
        checkOutput("err", 64'(respErr), 64'(expErr));
        heldData = respRdata;

        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            checkOutput("stallValid", 64'(respValid), 64'd1);
            checkOutput("stallRdata", respRdata, heldData);
            checkOutput("stallReqReady", 64'(reqReady), 64'd0);
        end

        respReady = 1'b1;
        @(negedge clk);
        respReady = 1'b0;
        checkOutput("postValid", 64'(respValid), 64'd0);
        checkOutput("postRdata", respRdata, 64'd0);
        checkOutput("postReqReady", 64'(reqReady), 64'd1);

        if (wen && ok) modelMem[key] = mergeBytes(modelMem.exists(key) ? modelMem[key] : 64'd0, wdata, wmask);
    endtask

    // req_valid held high across several loads: count accepts and check response order
    task automatic backToBack();
        logic [63:0] expQ [$];
        int accepts;
        int lastAcc;
        int seen;
        int guard;
        for (int i = 1; i <= 3; i++) expQ.push_back(modelMem[longint'(i)]);
        accepts = 0;
        lastAcc = 0;
        seen    = 0;
        @(negedge clk);
        respReady = 1'b1;
        reqValid  = 1'b1;
        reqWen    = 1'b0;
        reqAddr   = BASE + 64'd8;
        for (int it = 0; it < 3 * (LAT + 2); it++) begin
            if (reqReady && reqValid) begin
                if (accepts > 0) checkOutput("spacing", 64'(cycle - lastAcc >= LAT + 2), 64'd1);
                lastAcc = cycle;
                accepts++;
            end
            if (respValid) begin
                checkOutput("b2bRdata", respRdata, (seen < 3) ? expQ[seen] : 64'd0);
                seen++;
            end
            @(negedge clk);
            reqAddr = BASE + 64'(8 * (accepts + 1));
        end
        reqValid = 1'b0;
        checkOutput("b2bAccepts", 64'(accepts), 64'd3);
        guard = 0;
        while (seen < 3 && guard < 50) begin
            if (respValid) begin
                checkOutput("b2bRdata", respRdata, expQ[seen]);
                seen++;
            end
            @(negedge clk);
            guard++;
        end
        checkOutput("b2bResponses", 64'(seen), 64'd3);
        respReady = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstN      = 1'b0;
        reqValid  = 1'b0;
        reqWen    = 1'b0;
        reqAddr   = 64'd0;
        reqWdata  = 64'd0;
        reqWmask  = 64'd0;
        respReady = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rstReqReady", 64'(reqReady), 64'd0);
        checkOutput("rstRespValid", 64'(respValid), 64'd0);
        checkOutput("rstRdata", respRdata, 64'd0);
        checkOutput("rstErr", 64'(respErr), 64'd0);
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("relReqReady", 64'(reqReady), 64'd1);

        // Fill a working set of words plus the last word of the array
        for (int w = 0; w < 32; w++) begin
            applyStimulus(1'b1, BASE + 64'(8 * w), {$urandom, $urandom}, {64{1'b1}}, 0);
        end
        applyStimulus(1'b1, BASE + 64'(8 * (DEPTH - 1)), {$urandom, $urandom}, {64{1'b1}}, 0);

        // Store then load, then a single byte-lane merge
        applyStimulus(1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, {64{1'b1}}, 0);
        applyStimulus(1'b0, 64'h8000_0010, 64'd0, 64'd0, 0);
        applyStimulus(1'b1, 64'h8000_0010, 64'h0000_0000_00AB_0000, 64'h0000_0000_00ff_0000, 0);
        applyStimulus(1'b0, 64'h8000_0010, 64'd0, 64'd0, 0);
        checkOutput("byteMergeModel", modelMem[longint'(2)], 64'h1122_3344_55AB_7788);

        // Zero mask leaves the word alone; backpressure holds the response
        applyStimulus(1'b1, 64'h8000_0010, {$urandom, $urandom}, 64'd0, 2);
        applyStimulus(1'b0, 64'h8000_0010, 64'd0, 64'd0, 5);

        // Out-of-range / wrapped addresses
        applyStimulus(1'b0, 64'h8000_8000, 64'd0, 64'd0, 0);
        applyStimulus(1'b1, 64'h7FFF_FFF8, {$urandom, $urandom}, {64{1'b1}}, 1);
        applyStimulus(1'b0, BASE + 64'(8 * (DEPTH - 1)), 64'd0, 64'd0, 0);
        applyStimulus(1'b0, BASE, 64'd0, 64'd0, 0);

        // Randomised mixed traffic over the working set
        for (int n = 0; n < 40; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), BASE + 64'(8 * $urandom_range(0, 31)),
                          {$urandom, $urandom}, randomMask(), int'($urandom_range(0, 3)));
        end

        // Reset while an access is in BUSY discards it
        @(negedge clk);
        reqValid = 1'b1;
        reqWen   = 1'b1;
        reqAddr  = BASE;
        reqWdata = 64'hDEAD;
        reqWmask = {64{1'b1}};
        for (int g = 0; g < 50 && reqReady !== 1'b1; g++) @(negedge clk);
        @(negedge clk);
        reqValid = 1'b0;
        rstN     = 1'b0;
        #1;
        checkOutput("midRstReqReady", 64'(reqReady), 64'd0);
        checkOutput("midRstRespValid", 64'(respValid), 64'd0);
        checkOutput("midRstRdata", respRdata, 64'd0);
        checkOutput("midRstErr", 64'(respErr), 64'd0);
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("midRelReqReady", 64'(reqReady), 64'd1);
        applyStimulus(1'b0, BASE, 64'd0, 64'd0, 0);

        backToBack();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
